// File: rtl/dds_oscillator.sv
// Direct-digital-synthesis tone source: phase accumulator, four waveforms from the
// accumulator MSBs, amplitude scaling, and sample-valid / cycle-wrap strobes.
module dds_oscillator #(
    parameter int PHASE_W    = 24,
    parameter int LUT_ADDR_W = 5,
    parameter int DATA_W     = 8,
    parameter int AMP_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                sync,
    input  logic [PHASE_W-1:0]  tune_word,
    input  logic [1:0]          wave_sel,
    input  logic [AMP_W-1:0]    amplitude,
    output logic [DATA_W-1:0]   dataout,
    output logic                sample_valid,
    output logic                cycle_wrap
);

    localparam int                LUT_N   = 2 ** LUT_ADDR_W;
    localparam logic [DATA_W-1:0] MAX_VAL = {DATA_W{1'b1}};
    localparam int                PROD_W  = DATA_W + AMP_W;

    typedef enum logic [1:0] {
        FILL_EMPTY = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_FULL  = 2'd2
    } fill_t;

    function automatic logic [DATA_W-1:0] sine_point(input int k);
        real half;
        real ang;
        real v;
        half = real'((2 ** DATA_W) - 1) / 2.0;
        ang  = 2.0 * 3.14159265358979 * real'(k) / real'(LUT_N);
        v    = half * (1.0 + $sin(ang)) + 0.5;
        return DATA_W'($rtoi($floor(v)));
    endfunction

    logic [PHASE_W-1:0]    phase_q;
    logic [PHASE_W-1:0]    phase_d;
    logic                  carry_s;
    logic [DATA_W-1:0]     raw_q;
    logic [DATA_W-1:0]     raw_d;
    logic [DATA_W-1:0]     dataout_q;
    logic [DATA_W-1:0]     scaled_d;
    logic                  w0_q;
    logic                  w1_q;
    logic                  sample_valid_q;
    logic                  cycle_wrap_q;
    fill_t                 fill_q;
    fill_t                 fill_d;

    logic [DATA_W-1:0]     sine_lut_s [LUT_N];
    logic [DATA_W-1:0]     p_s;
    logic [LUT_ADDR_W-1:0] a_s;
    logic [DATA_W-1:0]     tri_s;
    logic [AMP_W:0]        amp_plus_s;
    logic [PROD_W-1:0]     product_s;

    for (genvar k = 0; k < LUT_N; k++) begin : g_sine_lut
        localparam logic [DATA_W-1:0] ENTRY = sine_point(k);
        assign sine_lut_s[k] = ENTRY;
    end

    // Accumulator advance; the carry out marks the start of a new waveform cycle
    always_comb begin
        {carry_s, phase_d} = {1'b0, phase_q} + {1'b0, tune_word};
    end

    // Waveform generation from the top bits of the current phase
    always_comb begin
        p_s   = phase_q[PHASE_W-1 -: DATA_W];
        a_s   = phase_q[PHASE_W-1 -: LUT_ADDR_W];
        tri_s = {p_s[DATA_W-2:0], 1'b0};
        case (wave_sel)
            2'd0:    raw_d = sine_lut_s[a_s];
            2'd1:    raw_d = p_s[DATA_W-1] ? {DATA_W{1'b0}} : MAX_VAL;
            2'd2:    raw_d = p_s;
            2'd3:    raw_d = p_s[DATA_W-1] ? ~tri_s : tri_s;
            default: raw_d = {DATA_W{1'b0}};
        endcase
    end

    // Amplitude scaling; (2^D-1)*2^A < 2^(D+A), so the product never needs a carry bit
    always_comb begin
        amp_plus_s = {1'b0, amplitude} + {{AMP_W{1'b0}}, 1'b1};
        product_s  = PROD_W'(raw_q) * PROD_W'(amp_plus_s);
        scaled_d   = product_s[AMP_W +: DATA_W];
    end

    // Pipeline fill sequencing: saturates at FULL once both stages hold real data
    always_comb begin
        case (fill_q)
            FILL_EMPTY: fill_d = FILL_ONE;
            FILL_ONE:   fill_d = FILL_FULL;
            FILL_FULL:  fill_d = FILL_FULL;
            default:    fill_d = FILL_EMPTY;
        endcase
    end

    // All pipeline state; sync restarts phase and fill but keeps the last sample on the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q        <= {PHASE_W{1'b0}};
            raw_q          <= {DATA_W{1'b0}};
            dataout_q      <= {DATA_W{1'b0}};
            w0_q           <= 1'b0;
            w1_q           <= 1'b0;
            fill_q         <= FILL_EMPTY;
            sample_valid_q <= 1'b0;
            cycle_wrap_q   <= 1'b0;
        end else if (sync) begin
            phase_q        <= {PHASE_W{1'b0}};
            w0_q           <= 1'b0;
            w1_q           <= 1'b0;
            fill_q         <= FILL_EMPTY;
            sample_valid_q <= 1'b0;
            cycle_wrap_q   <= 1'b0;
        end else if (en) begin
            phase_q        <= phase_d;
            w0_q           <= carry_s;
            raw_q          <= raw_d;
            w1_q           <= w0_q;
            dataout_q      <= scaled_d;
            cycle_wrap_q   <= w1_q & (fill_q == FILL_FULL);
            fill_q         <= fill_d;
            sample_valid_q <= (fill_q == FILL_FULL);
        end else begin
            sample_valid_q <= 1'b0;
            cycle_wrap_q   <= 1'b0;
        end
    end

    assign dataout      = dataout_q;
    assign sample_valid = sample_valid_q;
    assign cycle_wrap   = cycle_wrap_q;

endmodule

// File: tb/tb_dds_oscillator.sv
// Directed self-checking bench for dds_oscillator: reset, saw/sine/square/triangle,
// amplitude scaling, enable hold, sync restart and zero tuning word.
module tb_dds_oscillator;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sync;
    logic [23:0] tune_word;
    logic [1:0]  wave_sel;
    logic [7:0]  amplitude;
    logic [7:0]  dataout;
    logic        sample_valid;
    logic        cycle_wrap;

    int tests_run    = 0;
    int tests_failed = 0;

    dds_oscillator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sync         (sync),
        .tune_word    (tune_word),
        .wave_sel     (wave_sel),
        .amplitude    (amplitude),
        .dataout      (dataout),
        .sample_valid (sample_valid),
        .cycle_wrap   (cycle_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    function automatic logic [31:0] sine_ref(input int idx);
        case (idx)
            0:       return 32'd128;
            4:       return 32'd218;
            8:       return 32'd255;
            16:      return 32'd128;
            24:      return 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        int n;
        rst_n     = 1'b0;
        en        = 1'b0;
        sync      = 1'b0;
        tune_word = 24'h010000;
        wave_sel  = 2'd2;
        amplitude = 8'hFF;
        #12;
        check_eq("rst_data", 32'(dataout), 32'd0);
        check_eq("rst_valid", 32'(sample_valid), 32'd0);
        check_eq("rst_wrap", 32'(cycle_wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // saw ramp through one full cycle and into the next
        for (int e = 1; e <= 260; e++) begin
            step();
            check_eq("saw_data", 32'(dataout), (e >= 2) ? 32'((e - 2) % 256) : 32'd0);
            check_eq("saw_valid", 32'(sample_valid), (e >= 3) ? 32'd1 : 32'd0);
            check_eq("saw_wrap", 32'(cycle_wrap), (e == 258) ? 32'd1 : 32'd0);
        end

        // enable drop holds the output
        for (int i = 0; i < 38; i++) step();
        check_eq("en_pre", 32'(dataout), 32'd40);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("en_hold_data", 32'(dataout), 32'd40);
            check_eq("en_hold_valid", 32'(sample_valid), 32'd0);
        end
        en = 1'b1;
        step();
        check_eq("en_resume_41", 32'(dataout), 32'd41);
        check_eq("en_resume_valid", 32'(sample_valid), 32'd1);
        step();
        check_eq("en_resume_42", 32'(dataout), 32'd42);

        // sync restart mid-ramp
        for (int i = 0; i < 58; i++) step();
        check_eq("sync_pre", 32'(dataout), 32'd100);
        restart();
        check_eq("sync_hold_data", 32'(dataout), 32'd100);
        check_eq("sync_valid0", 32'(sample_valid), 32'd0);
        check_eq("sync_wrap0", 32'(cycle_wrap), 32'd0);
        step();
        check_eq("sync_e1_data", 32'(dataout), 32'd101);
        check_eq("sync_e1_valid", 32'(sample_valid), 32'd0);
        step();
        check_eq("sync_e2_data", 32'(dataout), 32'd0);
        check_eq("sync_e2_valid", 32'(sample_valid), 32'd0);
        step();
        check_eq("sync_e3_data", 32'(dataout), 32'd1);
        check_eq("sync_e3_valid", 32'(sample_valid), 32'd1);
        check_eq("sync_e3_wrap", 32'(cycle_wrap), 32'd0);
        step();
        check_eq("sync_e4_data", 32'(dataout), 32'd2);

        // sine table walk
        wave_sel  = 2'd0;
        tune_word = 24'h080000;
        restart();
        for (int e = 1; e <= 34; e++) begin
            step();
            n = (e - 2) % 32;
            if (e >= 3) check_eq("sine_valid", 32'(sample_valid), 32'd1);
            if (e >= 2 && (n == 0 || n == 4 || n == 8 || n == 16 || n == 24))
                check_eq("sine_data", 32'(dataout), sine_ref(n));
        end

        // square at half amplitude
        wave_sel  = 2'd1;
        tune_word = 24'h100000;
        amplitude = 8'h7F;
        restart();
        for (int e = 1; e <= 34; e++) begin
            step();
            if (e >= 2)
                check_eq("square_data", 32'(dataout), (((e - 2) % 16) < 8) ? 32'd127 : 32'd0);
        end

        // triangle across the half-cycle fold
        wave_sel  = 2'd3;
        tune_word = 24'h010000;
        amplitude = 8'hFF;
        restart();
        for (int e = 1; e <= 140; e++) begin
            step();
            n = e - 2;
            if (e >= 2)
                check_eq("tri_data", 32'(dataout),
                         (n < 128) ? 32'(2 * n) : 32'(255 - ((2 * n) & 255)));
        end

        // saw with amplitude 0x80: raw*129 >> 8
        wave_sel  = 2'd2;
        amplitude = 8'h80;
        restart();
        for (int e = 1; e <= 40; e++) begin
            step();
            if (e >= 2)
                check_eq("amp_data", 32'(dataout), 32'(((e - 2) * 129) >> 8));
        end

        // zero tuning word: frozen phase, no wraps
        amplitude = 8'hFF;
        tune_word = 24'h000000;
        restart();
        for (int e = 1; e <= 300; e++) begin
            step();
            check_eq("tw0_wrap", 32'(cycle_wrap), 32'd0);
            if (e >= 2) check_eq("tw0_data", 32'(dataout), 32'd0);
        end

        // asynchronous reset mid-cycle
        tune_word = 24'h010000;
        restart();
        for (int i = 0; i < 20; i++) step();
        check_eq("arst_pre_data", 32'(dataout), 32'd18);
        check_eq("arst_pre_valid", 32'(sample_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_data", 32'(dataout), 32'd0);
        check_eq("arst_valid", 32'(sample_valid), 32'd0);
        check_eq("arst_wrap", 32'(cycle_wrap), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            check_eq("arst_post_data", 32'(dataout), (e >= 2) ? 32'(e - 2) : 32'd0);
            check_eq("arst_post_valid", 32'(sample_valid), (e >= 3) ? 32'd1 : 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
